delay_line: RTL and testbench



---
 rtl/delay_line.sv | 179 +++++++++++++++++
 tb/tb_delay_line.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// delay_line
//
// Per-channel programmable sample delay. Every accepted echo sample is written
// into a 256-entry circular buffer. The block emits the sample that arrived
// 'delay' accepted samples earlier. The delay is loaded from delay_calc via a
// one-cycle strobe.
//
// Pipeline:
//   edge N   : read address, bypass data and output decision are registered.
//   edge N+1 : the RAM is read synchronously into sample_out, and out_valid
//              is raised for one cycle.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   delay_in      8-bit delay in samples (from delay_calc.delay_out)
//   delay_valid   one-cycle load strobe for delay_in (from delay_calc.done)
//   sample_in     DATA_W-bit echo sample
//   sample_valid  sample_in is accepted this cycle
//   sample_out    delayed sample (registered)
//   out_valid     one-cycle pulse per output on sample_out
//   delay_cur     currently active delay
//   debug_state   (DELAY_LINE_DEBUG_EN only) [1:0] FSM state
//                 (IDLE=0, FILL=1, RUN=2), [2] zero, [3] sticky underrun flag
//
// Optional feature macro: DELAY_LINE_DEBUG_EN adds the debug_state port and
// the underrun flag behind it.

module delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        delay_in,
  input  logic              delay_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic [7:0]        delay_cur
`ifdef DELAY_LINE_DEBUG_EN
  ,
  output logic [3:0]        debug_state
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [7:0]        wr_ptr_q, wr_ptr_d;
  logic [7:0]        fill_cnt_q, fill_cnt_d;
  logic [7:0]        delay_cur_q, delay_cur_d;

  logic              rd_valid_q;
  logic [7:0]        rd_addr_q;
  logic              byp_q;
  logic [DATA_W-1:0] byp_data_q;

  logic [DATA_W-1:0] sample_out_q;
  logic              out_valid_q;

  state_t            stateEff;
  logic [7:0]        delayEff;
  logic              histOk;
  logic              emit;
  logic [7:0]        rdAddr;

  // A same-cycle strobe applies to the sample in that cycle. Both the read
  // address and the FILL/RUN decision therefore use the incoming delay, and
  // the state is first advanced as if the strobe had already landed.
  always_comb begin
    delayEff    = delay_cur_q;
    stateEff    = state_q;
    delay_cur_d = delay_cur_q;
    if (delay_valid) begin
      delayEff    = delay_in;
      delay_cur_d = delay_in;
      if (state_q == IDLE) begin
        stateEff = FILL;
      end else if ((state_q == RUN) && (delay_in > fill_cnt_q)) begin
        stateEff = FILL;
      end
    end

    // fill_cnt_q is the count before the current sample is added.
    histOk = (fill_cnt_q >= delayEff);
    emit   = sample_valid && ((stateEff == RUN) || ((stateEff == FILL) && histOk));
    rdAddr = wr_ptr_q - delayEff;

    state_d = stateEff;
    if ((stateEff == FILL) && sample_valid && histOk) begin
      state_d = RUN;
    end

    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (sample_valid) begin
      wr_ptr_d = wr_ptr_q + 8'd1;
      if (fill_cnt_q != 8'hFF) begin
        fill_cnt_d = fill_cnt_q + 8'd1;
      end
    end
  end

  // Control state and the first pipeline stage. Delay 0 captures the input
  // sample directly, so no RAM read is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 8'd0;
      fill_cnt_q  <= 8'd0;
      delay_cur_q <= 8'd0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= 8'd0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      delay_cur_q <= delay_cur_d;
      rd_valid_q  <= emit;
      if (emit) begin
        rd_addr_q  <= rdAddr;
        byp_q      <= (delayEff == 8'd0);
        byp_data_q <= sample_in;
      end
    end
  end

  // The sample buffer is not cleared by reset.
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

  // Second stage: synchronous RAM read. With delay 255 the read address equals
  // the slot being written on the same edge. The read returns the old
  // contents, which is the sample wanted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        sample_out_q <= byp_q ? byp_data_q : mem[rd_addr_q];
      end
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign delay_cur  = delay_cur_q;

`ifdef DELAY_LINE_DEBUG_EN
  logic underrun_q;

  // Sticky flag: set when a sample is dropped while waiting for history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (sample_valid && (stateEff == FILL) && !histOk) begin
      underrun_q <= 1'b1;
    end
  end

  assign debug_state = {underrun_q, 1'b0, state_q};
`endif

endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line
//
// Self-checking bench for delay_line. The driver pushes expected outputs into
// a scoreboard queue. It computes each one from an unbounded history of every
// sample accepted since reset. A separate monitor pops from the queue and
// compares whenever out_valid is high.

module tb_delay_line;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        delay_in = 8'd0;
  logic              delay_valid = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_out;
  logic              out_valid;
  logic [7:0]        delay_cur;

  int checks = 0;
  int failures = 0;
  int outCount = 0;
  int startCount = 0;

  logic [DATA_W-1:0] expQ[$];
  logic [DATA_W-1:0] hist[$];
  int                modelCount = 0;
  bit                modelLoaded = 1'b0;
  logic [7:0]        modelDelay = 8'd0;

  delay_line #(.DATA_W(DATA_W), .DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .delay_in     (delay_in),
    .delay_valid  (delay_valid),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .delay_cur    (delay_cur)
  );

  always #5 clk = ~clk;

  // Compare one value and log it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model. A sample is output once a delay has been loaded and
  // at least 'delay' samples have been accepted before it. Its value is
  // the sample 'delay' positions back in the accepted history.
  task automatic modelStep(input bit sv, input logic [DATA_W-1:0] data,
                           input bit dv, input logic [7:0] din);
    int d;
    int n;
    if (sv) begin
      d = dv ? int'(din) : int'(modelDelay);
      n = modelCount;
      hist.push_back(data);
      if ((modelLoaded || dv) && (n >= d)) begin
        expQ.push_back(hist[n - d]);
      end
      modelCount++;
    end
    if (dv) begin
      modelDelay  = din;
      modelLoaded = 1'b1;
    end
  endtask

  // Drive one clock cycle of inputs. The model is updated at the same edge.
  task automatic applyStimulus(input bit sv, input logic [DATA_W-1:0] data,
                               input bit dv, input logic [7:0] din);
    sample_valid = sv;
    sample_in    = data;
    delay_valid  = dv;
    delay_in     = din;
    @(posedge clk);
    modelStep(sv, data, dv, din);
    #1;
    sample_valid = 1'b0;
    delay_valid  = 1'b0;
  endtask

  task automatic ramp(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b0, 8'd0);
    end
  endtask

  // Assert reset away from a clock edge. Check that outputs clear at once,
  // without waiting for a clock.
  task automatic doReset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    delay_valid  = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sample_out", 32'(sample_out), 32'd0);
    checkOutput("reset_delay_cur", 32'(delay_cur), 32'd0);
    expQ.delete();
    hist.delete();
    modelCount  = 0;
    modelLoaded = 1'b0;
    modelDelay  = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    startCount = outCount;
  endtask

  // Let the pipeline empty, then check how many outputs the scenario produced.
  task automatic drainAndCount(input string name, input int expected);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 8'd0);
    checkOutput(name, 32'(outCount - startCount), 32'(expected));
    checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: pop and compare on every output pulse, and track delay_cur.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("delay_cur", 32'(delay_cur), 32'(modelDelay));
      if (out_valid === 1'b1) begin
        outCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL out_valid: got 1 with no output pending, expected 0");
        end else begin
          checkOutput("sample_out", 32'(sample_out), 32'(expQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] delay_line bench start");

    // No delay loaded: samples are absorbed silently.
    doReset();
    ramp(0, 9);
    drainAndCount("idle_outputs", 0);
    checkOutput("idle_sample_out", 32'(sample_out), 32'd0);

    // Delay 4, ramp 0..19: outputs for inputs 4..19.
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 8'd4);
    ramp(0, 19);
    drainAndCount("delay4_outputs", 16);

    // Delay 0 bypass: every sample comes out, including the first.
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 8'd0);
    ramp(0, 9);
    drainAndCount("bypass_outputs", 10);

    // Mid-run change from delay 2 to 20 after 10 samples.
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 8'd2);
    ramp(0, 9);
    applyStimulus(1'b0, '0, 1'b1, 8'd20);
    ramp(10, 29);
    drainAndCount("change_outputs", 18);

    // Pointer wrap with the maximum delay.
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 8'd255);
    ramp(0, 599);
    drainAndCount("wrap_outputs", 345);

    // Strobe coincident with sample 3, then reset mid-ramp.
    doReset();
    ramp(0, 2);
    applyStimulus(1'b1, DATA_W'(3), 1'b1, 8'd3);
    ramp(4, 9);
    checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
    doReset();
    ramp(0, 9);
    drainAndCount("post_reset_outputs", 0);

    // Randomized traffic with gaps, occasional and back-to-back reloads.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      bit              sv;
      bit              dv;
      logic [7:0]      din;
      logic [DATA_W-1:0] data;
      sv   = ($urandom_range(0, 3) != 0);
      dv   = ($urandom_range(0, 39) == 0);
      din  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 24));
      data = DATA_W'($urandom);
      applyStimulus(sv, data, dv, din);
    end
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 8'd0);
    checkOutput("random_pending", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
